// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: accepts parallel words over a valid/ready handshake, shifts
// them MSB-first through a programmable Mealy bit-pattern matcher (one bit per
// clock), and reports per-bit match pulses, per-word and running match counts.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cfg_we/_pattern/_len/_overlap  run-time matcher configuration (IDLE only)
//   s_valid, s_data, s_ready input word handshake
//   busy, bit_valid, bit_out serializer status and current stream bit
//   match                    match pulse in the same cycle as the completing bit
//   done, word_matches       end-of-word pulse with that word's match count
//   total_matches            saturating running total
//   first_pos, first_pos_valid  (only with SEQ_FIRST_POS_EN defined) index of
//                            the first match in the finished word
//
// Optional feature macro: SEQ_FIRST_POS_EN.
module seq_stream_ctrl #(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [PAT_MAX-1:0]         cfg_pattern,
  input  logic [$clog2(PAT_MAX):0]   cfg_len,
  input  logic                       cfg_overlap,
  input  logic                       s_valid,
  input  logic [WORD_W-1:0]          s_data,
  output logic                       s_ready,
  output logic                       busy,
  output logic                       bit_valid,
  output logic                       bit_out,
  output logic                       match,
  output logic                       done,
  output logic [$clog2(WORD_W):0]    word_matches,
`ifdef SEQ_FIRST_POS_EN
  output logic [CNT_W-1:0]           total_matches,
  output logic [$clog2(WORD_W)-1:0]  first_pos,
  output logic                       first_pos_valid
`else
  output logic [CNT_W-1:0]           total_matches
`endif
);

  localparam int LEN_W = $clog2(PAT_MAX) + 1;
  localparam int WM_W  = $clog2(WORD_W) + 1;
  localparam int IDX_W = $clog2(WORD_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [PAT_MAX-1:0] PAT_DEFAULT = PAT_MAX'(4'b1101);
  localparam logic [LEN_W-1:0]   LEN_DEFAULT = LEN_W'(4);

  logic [1:0]         state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [PAT_MAX-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   seen_q, seen_d;
  logic [WM_W-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   total_q, total_d;
`ifdef SEQ_FIRST_POS_EN
  logic [IDX_W-1:0]   fpos_q, fpos_d;
  logic               fvld_q, fvld_d;
`endif

  logic [LEN_W-1:0]   len_clamp;
  logic [PAT_MAX-1:0] window;
  logic [PAT_MAX-1:0] len_mask;
  logic               seen_ok;
  logic               match_w;

  // Outputs derived from registered state
  assign s_ready       = !rst && (state_q == ST_IDLE) && !cfg_we;
  assign busy          = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bit_valid     = (state_q == ST_SHIFT);
  assign bit_out       = bit_valid && word_q[WORD_W-1];
  assign done          = (state_q == ST_DONE);
  assign word_matches  = wcnt_q;
  assign total_matches = total_q;
  assign match         = match_w;
`ifdef SEQ_FIRST_POS_EN
  assign first_pos       = fpos_q;
  assign first_pos_valid = fvld_q;
`endif

  // Length 0 behaves as a single-bit pattern; oversize lengths clip to PAT_MAX
  always_comb begin
    len_clamp = cfg_len;
    if (cfg_len == '0) begin
      len_clamp = LEN_W'(1);
    end else if (cfg_len > LEN_W'(PAT_MAX)) begin
      len_clamp = LEN_W'(PAT_MAX);
    end
  end

  // Newest bit sits at window[0], so it lines up with pattern bit 0
  assign window  = {hist_q, bit_out};
  assign seen_ok = (seen_q >= (len_q - LEN_W'(1)));

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign match_w = bit_valid && seen_ok && (((window ^ pat_q) & len_mask) == '0);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    seen_d  = seen_q;
    wcnt_d  = wcnt_q;
    total_d = total_q;
`ifdef SEQ_FIRST_POS_EN
    fpos_d  = fpos_q;
    fvld_d  = fvld_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          // Configuration wins over an offered word in the same cycle
          pat_d  = cfg_pattern;
          len_d  = len_clamp;
          ovl_d  = cfg_overlap;
          hist_d = '0;
          seen_d = '0;
        end else if (s_valid) begin
          word_d  = s_data;
          idx_d   = '0;
          wcnt_d  = '0;
          state_d = ST_SHIFT;
`ifdef SEQ_FIRST_POS_EN
          fpos_d  = '0;
          fvld_d  = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        word_d = word_q << 1;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(WORD_W - 1)) begin
          state_d = ST_DONE;
        end
        if (match_w && !ovl_q) begin
          // Non-overlapping: restart detection after a hit
          hist_d = '0;
          seen_d = '0;
        end else begin
          hist_d = window[PAT_MAX-2:0];
          if (seen_q != LEN_W'(PAT_MAX)) begin
            seen_d = seen_q + LEN_W'(1);
          end
        end
        if (match_w) begin
          wcnt_d = wcnt_q + WM_W'(1);
          if (total_q != {CNT_W{1'b1}}) begin
            total_d = total_q + CNT_W'(1);
          end
`ifdef SEQ_FIRST_POS_EN
          if (!fvld_q) begin
            fpos_d = idx_q;
            fvld_d = 1'b1;
          end
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      pat_q   <= PAT_DEFAULT;
      len_q   <= LEN_DEFAULT;
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      seen_q  <= '0;
      wcnt_q  <= '0;
      total_q <= '0;
`ifdef SEQ_FIRST_POS_EN
      fpos_q  <= '0;
      fvld_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      wcnt_q  <= wcnt_d;
      total_q <= total_d;
`ifdef SEQ_FIRST_POS_EN
      fpos_q  <= fpos_d;
      fvld_q  <= fvld_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Directed bench for seq_stream_ctrl: default config, non-overlap, cross-word,
// short pattern, config/word collision, mid-word reset, counter saturation.
module tb_seq_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_we, cfg_overlap, s_valid;
  logic [7:0] cfg_pattern, s_data;
  logic [3:0] cfg_len;
  logic       s_ready, busy, bit_valid, bit_out, match, done;
  logic [3:0] word_matches;
  logic [15:0] total_matches;

  logic       rst2, cfg_we2, cfg_overlap2, s_valid2;
  logic [7:0] cfg_pattern2, s_data2;
  logic [3:0] cfg_len2;
  logic       s_ready2, busy2, bit_valid2, bit_out2, match2, done2;
  logic [3:0] word_matches2;
  logic [1:0] total_matches2;

`ifdef SEQ_FIRST_POS_EN
  logic [2:0] first_pos, first_pos2;
  logic       first_pos_valid, first_pos_valid2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_stream_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .busy(busy), .bit_valid(bit_valid),
    .bit_out(bit_out), .match(match), .done(done),
    .word_matches(word_matches),
`ifdef SEQ_FIRST_POS_EN
    .first_pos(first_pos), .first_pos_valid(first_pos_valid),
`endif
    .total_matches(total_matches)
  );

  seq_stream_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst2), .cfg_we(cfg_we2), .cfg_pattern(cfg_pattern2),
    .cfg_len(cfg_len2), .cfg_overlap(cfg_overlap2), .s_valid(s_valid2),
    .s_data(s_data2), .s_ready(s_ready2), .busy(busy2), .bit_valid(bit_valid2),
    .bit_out(bit_out2), .match(match2), .done(done2),
    .word_matches(word_matches2),
`ifdef SEQ_FIRST_POS_EN
    .first_pos(first_pos2), .first_pos_valid(first_pos_valid2),
`endif
    .total_matches(total_matches2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cyc();
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    #1;
    chk("cfg_s_ready_low", s_ready, 0);
    cyc();
    cfg_we = 1'b0;
  endtask

  // exp_m bit i = expected match at stream bit index i (0 = MSB)
  task automatic send_word(input logic [7:0] d, input logic [7:0] exp_m,
                           input logic [3:0] exp_wm, input logic [15:0] exp_tot,
                           input logic [2:0] exp_fp, input logic exp_fv);
    cyc();
    s_valid = 1'b1; s_data = d;
    #1;
    chk("s_ready", s_ready, 1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      s_valid = 1'b0;
      #1;
      chk("bit_valid", bit_valid, 1);
      chk("bit_out", bit_out, d[7-i]);
      chk("match", match, exp_m[i]);
      chk("done_early", done, 0);
    end
    cyc();
    #1;
    chk("done", done, 1);
    chk("word_matches", word_matches, exp_wm);
    chk("total_matches", total_matches, exp_tot);
`ifdef SEQ_FIRST_POS_EN
    chk("first_pos", first_pos, exp_fp);
    chk("first_pos_valid", first_pos_valid, exp_fv);
`else
    if (exp_fv) chk("fp_unused", 0, {29'd0, exp_fp} & 0);
`endif
    cyc();
    #1;
    chk("done_after", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nm;
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    s_valid = 1'b0; s_data = '0;
    rst2 = 1'b1; cfg_we2 = 1'b0; cfg_pattern2 = '0; cfg_len2 = '0; cfg_overlap2 = 1'b0;
    s_valid2 = 1'b0; s_data2 = '0;

    // Reset state
    cyc();
    #1;
    chk("rst_s_ready", s_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", s_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_bit_valid", bit_valid, 0);
    chk("post_rst_bit_out", bit_out, 0);
    chk("post_rst_match", match, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_wm", word_matches, 0);
    chk("post_rst_total", total_matches, 0);

    // Default 1101 overlapping: hits at indices 3 and 6
    send_word(8'hDA, 8'h48, 4'd2, 16'd2, 3'd3, 1'b1);

    // Non-overlapping: only index 3
    cfg(8'h0D, 4'd4, 1'b0);
    send_word(8'hDA, 8'h08, 4'd1, 16'd3, 3'd3, 1'b1);

    // Cross-word match lands in the later word
    cfg(8'h0D, 4'd4, 1'b1);
    send_word(8'h06, 8'h00, 4'd0, 16'd3, 3'd0, 1'b0);
    send_word(8'h80, 8'h01, 4'd1, 16'd4, 3'd0, 1'b1);

    // Pattern 010, len 3, overlapping: indices 2, 4, 6
    cfg(8'h02, 4'd3, 1'b1);
    send_word(8'h55, 8'h54, 4'd3, 16'd7, 3'd2, 1'b1);

    // Config and word offered together: config wins, word taken next cycle
    cyc();
    cfg_we = 1'b1; cfg_pattern = 8'h02; cfg_len = 4'd3; cfg_overlap = 1'b1;
    s_valid = 1'b1; s_data = 8'h40;
    #1;
    chk("collide_s_ready", s_ready, 0);
    cyc();
    cfg_we = 1'b0;
    #1;
    chk("collide_s_ready_next", s_ready, 1);
    chk("collide_busy", busy, 0);
    cyc();
    s_valid = 1'b0;
    #1;
    chk("collide_bit0", bit_out, 0);
    cyc();
    cyc();
    #1;
    chk("collide_match_new_cfg", match, 1);
    cyc();
    rst = 1'b1;
    #1;
    chk("midrst_s_ready", s_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("midrst_s_ready_after", s_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_bit_valid", bit_valid, 0);
    chk("midrst_match", match, 0);
    chk("midrst_wm", word_matches, 0);
    chk("midrst_total", total_matches, 0);
    nm = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      #1;
      if (done) nm++;
    end
    chk("midrst_no_done", nm, 0);
    // Defaults restored: 1101 overlapping again
    send_word(8'hDA, 8'h48, 4'd2, 16'd2, 3'd3, 1'b1);

    // Saturating total with a 2-bit counter; cfg_len 0 acts as len 1
    cyc();
    rst2 = 1'b0;
    cyc();
    cfg_we2 = 1'b1; cfg_pattern2 = 8'h01; cfg_len2 = 4'd0; cfg_overlap2 = 1'b1;
    cyc();
    cfg_we2 = 1'b0; s_valid2 = 1'b1; s_data2 = 8'hFF;
    #1;
    chk("sat_s_ready", s_ready2, 1);
    nm = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      s_valid2 = 1'b0;
      #1;
      if (match2) nm++;
      if (done2) break;
    end
    chk("sat_done", done2, 1);
    chk("sat_match_pulses", nm, 8);
    chk("sat_wm", word_matches2, 8);
    chk("sat_total", total_matches2, 3);
`ifdef SEQ_FIRST_POS_EN
    chk("sat_first_pos", first_pos2, 0);
    chk("sat_first_pos_valid", first_pos_valid2, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
